// File: rtl/regs_loader.sv
// Register-file loader: accepts (id, value) beats, writes them through a
// dedicated regfile port and stalls the core until all 32 ids are supplied.
module regs_loader (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_id,
  input  logic [63:0] in_data,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        hold_core,
  output logic        done,
  output logic        dup_err,
  output logic [31:0] loaded
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        in_ready_s;
  logic        hs_s;
  logic        begin_s;
  logic [31:0] id_bit_s;
  logic        rf_wen_r;
  logic [4:0]  rf_waddr_r;
  logic [63:0] rf_wdata_r;
  logic        dup_err_r;
  logic [31:0] loaded_r;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, beat acceptance and session-start decode
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    begin_s     = 1'b0;
    id_bit_s    = 32'd1 << in_id;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          begin_s     = 1'b1;
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          in_ready_s = 1'b1;
          // A beat that fills the last missing id ends the session
          if (in_valid && ((loaded_r | id_bit_s) == 32'hFFFF_FFFF)) begin
            state_nxt_s = FINISH;
          end else begin
            state_nxt_s = LOAD;
          end
        end
      end
      FINISH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    hs_s = in_valid && in_ready_s;
  end

  // Registered regfile write port and session bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_wen_r   <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= 64'd0;
      loaded_r   <= 32'd0;
      dup_err_r  <= 1'b0;
    end else begin
      // x0 is hardwired, so its beat only marks the id as loaded
      rf_wen_r <= hs_s && (in_id != 5'd0);
      if (hs_s) begin
        rf_waddr_r <= in_id;
        rf_wdata_r <= in_data;
      end
      if (begin_s) begin
        loaded_r  <= 32'd0;
        dup_err_r <= 1'b0;
      end else if (hs_s) begin
        loaded_r <= loaded_r | id_bit_s;
        if ((loaded_r & id_bit_s) != 32'd0) begin
          dup_err_r <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign rf_wen    = rf_wen_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign hold_core = (state_r != IDLE);
  assign done      = (state_r == FINISH);
  assign dup_err   = dup_err_r;
  assign loaded    = loaded_r;

endmodule

// File: tb/tb_regs_loader.sv
// Self-checking bench for regs_loader: vector table, directed sessions and
// randomized bubbles, all checked against a set-based reference model.
module tb_regs_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_id = 5'd0;
  logic [63:0] in_data = 64'd0;
  logic        in_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        hold_core;
  logic        done;
  logic        dup_err;
  logic [31:0] loaded;

  regs_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_data(in_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hold_core(hold_core), .done(done), .dup_err(dup_err), .loaded(loaded)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Reference model: session phase, set of received ids, pending write
  bit          m_active, m_finish, m_dup, m_wen;
  logic [31:0] m_loaded;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  logic [63:0] rf_shadow [32];
  int          wen_cnt, hold_cnt, done_cnt;

  typedef struct {
    bit          s, a, v;
    logic [4:0]  id;
    logic [63:0] d;
    bit          exp_rdy, exp_hold_next, exp_done_next;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_finish = 1'b0; m_dup = 1'b0; m_wen = 1'b0;
    m_loaded = 32'd0; m_waddr = 5'd0; m_wdata = 64'd0;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 32; i++) rf_shadow[i] = 64'd0;
    wen_cnt = 0; hold_cnt = 0; done_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("rf_wen", rf_wen, m_wen);
    if (m_wen) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    chk("hold_core", hold_core, m_active | m_finish);
    chk("done", done, m_finish);
    chk("dup_err", dup_err, m_dup);
    chk("loaded", loaded, m_loaded);
    if (rf_wen) begin rf_shadow[rf_waddr] = rf_wdata; wen_cnt++; end
    if (hold_core) hold_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic model_update(input bit s, input bit a, input bit v,
                              input logic [4:0] id, input logic [63:0] d);
    bit accept;
    accept = m_active && !a && v;
    m_wen = accept && (id != 5'd0);
    if (accept) begin m_waddr = id; m_wdata = d; end
    if (m_finish) begin
      m_finish = 1'b0;
    end else if (m_active) begin
      if (a) m_active = 1'b0;
      else if (accept) begin
        if (m_loaded[id]) m_dup = 1'b1;
        m_loaded[id] = 1'b1;
        if (m_loaded == 32'hFFFF_FFFF) begin m_active = 1'b0; m_finish = 1'b1; end
      end
    end else if (s && !a) begin
      m_active = 1'b1; m_loaded = 32'd0; m_dup = 1'b0;
    end
  endtask

  // One cycle: check last cycle's registered outputs, drive inputs, check in_ready
  task automatic step(input bit s, input bit a, input bit v,
                      input logic [4:0] id, input logic [63:0] d);
    @(negedge clock);
    check_outputs();
    start = s; abort = a; in_valid = v; in_id = id; in_data = d;
    #1;
    chk("in_ready", in_ready, m_active && !a);
    model_update(s, a, v, id, d);
  endtask

  task automatic beat(input logic [4:0] id, input logic [63:0] d);
    step(1'b0, 1'b0, 1'b1, id, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  vec_t tbl [7];
  bit [31:0] uniq;

  initial begin
    model_reset();
    clear_log();
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    chk("rst_hold", hold_core, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dup", dup_err, 1'b0);
    chk("rst_loaded", loaded, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Short control vectors from IDLE: stray beat, start+abort, start,
    // beat, start during LOAD, abort with beat, beat back in IDLE
    tbl[0] = '{1'b0, 1'b0, 1'b1, 5'd3, 64'h11, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 5'd0, 64'h0,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 5'd3, 64'h33, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 5'd4, 64'h44, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 5'd5, 64'h55, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 5'd6, 64'h66, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].s, tbl[i].a, tbl[i].v, tbl[i].id, tbl[i].d);
      chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].exp_rdy);
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_hold", i), hold_core, tbl[i].exp_hold_next);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].exp_done_next);
    end
    chk("tbl_loaded", loaded, 32'h0000_0018);
    idle(2);

    // Full load, ids 31..0 back to back
    clear_log();
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    for (int id = 31; id >= 0; id--) beat(5'(id), 64'h1000 + 64'(id));
    idle(3);
    chk("full_wen_cnt", wen_cnt, 31);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_hold_span", hold_cnt + 1, 34);  // start cycle plus 33 held cycles
    chk("full_dup", dup_err, 1'b0);
    chk("full_x0_untouched", rf_shadow[0], 64'd0);
    for (int i = 1; i < 32; i++) chk($sformatf("full_x%0d", i), rf_shadow[i], 64'h1000 + 64'(i));

    // Duplicate id 5: 0xAA then 0xBB
    clear_log();
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    for (int id = 0; id < 32; id++) begin
      if (id == 5) begin
        beat(5'd5, 64'hAA);
        beat(5'd5, 64'hBB);
      end else beat(5'(id), 64'h2000 + 64'(id));
    end
    idle(2);
    chk("dup_last_x5", rf_shadow[5], 64'hBB);
    chk("dup_sticky", dup_err, 1'b1);
    chk("dup_done_cnt", done_cnt, 1);
    chk("dup_wen_cnt", wen_cnt, 32);

    // Bubbles with random ids and random valid
    clear_log();
    uniq = 32'd0;
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    for (int i = 0; i < 60; i++) begin
      bit v;
      bit acc;
      logic [4:0] id;
      v = 1'($urandom_range(0, 1));
      id = 5'($urandom_range(0, 31));
      acc = m_active && v;
      step(1'b0, 1'b0, v, id, {$urandom, $urandom});
      if (acc) uniq[id] = 1'b1;
    end
    idle(1);
    chk("bubble_popcount", $countones(loaded), $countones(uniq));
    for (int id = 0; id < 32; id++) if (!uniq[id]) beat(5'(id), 64'(id));
    idle(2);
    chk("bubble_done_cnt", done_cnt, 1);
    chk("bubble_loaded", loaded, 32'hFFFF_FFFF);

    // Abort after 10 beats, colliding with a valid beat
    clear_log();
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    for (int id = 10; id < 20; id++) beat(5'(id), 64'h3000 + 64'(id));
    step(1'b0, 1'b1, 1'b1, 5'd20, 64'hDEAD);
    idle(2);
    chk("abort_popcount", $countones(loaded), 10);
    chk("abort_no_write", rf_shadow[20], 64'd0);
    chk("abort_done_cnt", done_cnt, 0);
    chk("abort_wen_cnt", wen_cnt, 10);

    // Reset after 7 beats
    clear_log();
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    for (int id = 0; id < 7; id++) beat(5'(id), 64'h4000 + 64'(id));
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 1'b0);
    chk("mrst_rf_wen", rf_wen, 1'b0);
    chk("mrst_rf_waddr", rf_waddr, 5'd0);
    chk("mrst_rf_wdata", rf_wdata, 64'd0);
    chk("mrst_hold", hold_core, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_loaded", loaded, 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    idle(1);
    chk("mrst_clean_loaded", loaded, 32'd0);
    for (int id = 31; id >= 0; id--) beat(5'(id), 64'h5000 + 64'(id));
    idle(2);

    // Start pulses during LOAD and FINISH are ignored
    clear_log();
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    for (int id = 0; id < 15; id++) beat(5'(id), 64'(id));
    step(1'b1, 1'b0, 1'b1, 5'd15, 64'd15);
    for (int id = 16; id < 32; id++) beat(5'(id), 64'(id));
    step(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    idle(2);
    chk("istart_done_cnt", done_cnt, 1);
    chk("istart_loaded", loaded, 32'hFFFF_FFFF);
    chk("istart_hold", hold_core, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
